// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the multi-channel key debouncer.
//   key_state_e : per-channel FSM state encoding
//   max3        : maximum of three values, used to size the shared counters
package key_pkg;

    // Per-channel conditioner state
    typedef enum logic [2:0] {
        RELEASED = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        LONG     = 3'd3,
        REL_DB   = 3'd4
    } key_state_e;

    // Largest of three cycle counts; evaluated at elaboration time
    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-flop synchroniser, debounce FSM,
// hold counter for long-press and auto-repeat events.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_in       : raw asynchronous key pin
//   key_status   : debounced level, 1 = pressed
//   key_press    : 1-cycle pulse on accepted press
//   key_release  : 1-cycle pulse on accepted release
//   key_long     : 1-cycle pulse when the hold reaches LONG_CYCLES
//   key_repeat   : 1-cycle pulse every REPEAT_CYCLES while long-held
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter logic        PRESS_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_status,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int unsigned CNT_MAX   = max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_END   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             REPEAT_EN = (REPEAT_CYCLES != 0);

    // Synchroniser idles at the released level so a key held through reset
    // is seen as a fresh press.
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= ~PRESS_LEVEL;
            sync_q2 <= ~PRESS_LEVEL;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    logic pressed;
    assign pressed = (sync_q2 == PRESS_LEVEL);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             was_long_q, was_long_d;
    logic             status_d, press_d, release_d, long_d, repeat_d;

    // Saturating increments; counters never wrap
    logic [CNT_W-1:0] db_inc;
    logic [CNT_W-1:0] hold_inc;
    logic             long_hit;
    logic             rep_hit;

    assign db_inc   = (db_cnt_q   == '1) ? db_cnt_q   : db_cnt_q   + CNT_ONE;
    assign hold_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_ONE;
    // Thresholds are tested on the incremented value so the event lands
    // exactly N cycles after the counter was cleared.
    assign long_hit = (hold_inc == LONG_END);
    assign rep_hit  = REPEAT_EN && (hold_inc == REP_END);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RELEASED;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            was_long_q  <= 1'b0;
            key_status  <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            was_long_q  <= was_long_d;
            key_status  <= status_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
            key_repeat  <= repeat_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        was_long_d = was_long_q;
        status_d   = key_status;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (pressed) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = CNT_ONE;
                end
            end

            PRESS_DB: begin
                if (!pressed) begin
                    state_d  = RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_END) begin
                    state_d    = HELD;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    status_d   = 1'b1;
                    press_d    = 1'b1;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            HELD: begin
                if (!pressed) begin
                    state_d    = REL_DB;
                    db_cnt_d   = CNT_ONE;
                    was_long_d = 1'b0;
                end else if (long_hit) begin
                    state_d    = LONG;
                    hold_cnt_d = '0;
                    long_d     = 1'b1;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end

            LONG: begin
                if (!pressed) begin
                    state_d    = REL_DB;
                    db_cnt_d   = CNT_ONE;
                    was_long_d = 1'b1;
                end else if (rep_hit) begin
                    hold_cnt_d = '0;
                    repeat_d   = 1'b1;
                end else if (REPEAT_EN) begin
                    hold_cnt_d = hold_inc;
                end
            end

            REL_DB: begin
                // hold_cnt is frozen here; a bounce back resumes counting
                // from where the hold left off.
                if (pressed) begin
                    db_cnt_d = '0;
                    if (was_long_q) begin
                        state_d = LONG;
                        if (rep_hit) begin
                            hold_cnt_d = '0;
                            repeat_d   = 1'b1;
                        end else if (REPEAT_EN) begin
                            hold_cnt_d = hold_inc;
                        end
                    end else begin
                        state_d = HELD;
                        if (long_hit) begin
                            state_d    = LONG;
                            hold_cnt_d = '0;
                            long_d     = 1'b1;
                        end else begin
                            hold_cnt_d = hold_inc;
                        end
                    end
                end else if (db_cnt_q == DB_END) begin
                    state_d    = RELEASED;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    status_d   = 1'b0;
                    release_d  = 1'b1;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            default: begin
                state_d    = RELEASED;
                db_cnt_d   = '0;
                hold_cnt_d = '0;
                status_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: NUM_KEYS independent push-button conditioners.
// Ports:
//   sys_clk      : system clock, rising edge
//   sys_rst      : asynchronous active-low reset
//   key_in       : raw asynchronous key pins
//   key_status   : debounced levels, 1 = pressed
//   key_press    : per-key 1-cycle pulse on accepted press
//   key_release  : per-key 1-cycle pulse on accepted release
//   key_long     : per-key 1-cycle pulse on long-press
//   key_repeat   : per-key 1-cycle auto-repeat pulse while long-held
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter logic        PRESS_LEVEL     = 1'b0
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_status,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    // One fully independent conditioner per key pin
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .PRESS_LEVEL     (PRESS_LEVEL)
        ) u_ch (
            .clk         (sys_clk),
            .rst_n       (sys_rst),
            .key_in      (key_in[i]),
            .key_status  (key_status[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel push-button conditioner, the next-generation key debouncer. Each channel synchronises a raw key pin, rejects bounce shorter than a programmable window, and reports a stable level. It also emits single-cycle press, release, long-press and auto-repeat event pulses. It sits directly behind the board key pins and feeds UI/control logic running on `sys_clk`.

## Interface
- `NUM_KEYS`, 4, number of independent key channels (≥1)
- `DEBOUNCE_CYCLES`, 1_000_000, stable-input cycles needed to accept a level change (20 ms @ 50 MHz; ≥1)
- `LONG_CYCLES`, 50_000_000, cycles from the press pulse to the long-press pulse (≥1)
- `REPEAT_CYCLES`, 10_000_000, auto-repeat period after long press; 0 disables repeat
- `PRESS_LEVEL`, 1'b0, raw pin level meaning "pressed"
- `sys_clk`  in  1  system clock, all logic on rising edge
- `sys_rst`  in  1  asynchronous, active-low reset
- `key_in`  in  NUM_KEYS  raw asynchronous key pins
- `key_status`  out  NUM_KEYS  debounced level, 1 = pressed
- `key_press`  out  NUM_KEYS  1-cycle pulse on accepted press
- `key_release`  out  NUM_KEYS  1-cycle pulse on accepted release
- `key_long`  out  NUM_KEYS  1-cycle pulse when hold reaches LONG_CYCLES
- `key_repeat`  out  NUM_KEYS  1-cycle pulse every REPEAT_CYCLES while long-held

## Operation
- Per channel: 2-flop synchroniser, then `p = (sync == PRESS_LEVEL)`.
- Synchroniser flops reset to `~PRESS_LEVEL`, so a key held through reset is treated as a fresh press.
- Counters: `db_cnt` and `hold_cnt`, each `$clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)+1)` bits, unsigned, saturating, never wrapping.
- FSM states and transitions:
  - RELEASED: when `p`, go to PRESS_DB and set `db_cnt = 1`.
  - PRESS_DB:
    - `!p` → RELEASED; bounce is rejected with no pulse.
    - Otherwise `db_cnt++`. When `db_cnt == DEBOUNCE_CYCLES` and `p`, go to HELD: pulse `key_press`, set `key_status = 1`, `hold_cnt = 0`.
  - HELD:
    - `hold_cnt++`. At `hold_cnt == LONG_CYCLES`, pulse `key_long`, go to LONG, `hold_cnt = 0`.
    - `!p` → REL_DB with `db_cnt = 1`.
  - LONG:
    - If `REPEAT_CYCLES != 0`: `hold_cnt++`; at `hold_cnt == REPEAT_CYCLES`, pulse `key_repeat` and set `hold_cnt = 0`.
    - `!p` → REL_DB.
  - REL_DB:
    - `hold_cnt` is frozen. A `p` returns to the state it came from (HELD or LONG, recorded in a `was_long` bit); `hold_cnt` resumes and no pulse is emitted.
    - When `db_cnt == DEBOUNCE_CYCLES` with `!p`, pulse `key_release`, set `key_status = 0`, go to RELEASED.
- `key_release` fires for both short and long holds.
- Channels are fully independent; any number of channels may pulse in the same cycle.
- At most one event pulse per channel per cycle. Event pulses are never asserted while `key_status` disagrees with the state (press and status rise together; release and status fall together).

## Timing
- Reset (async assert, sync-released use): every output is 0, FSM in RELEASED, counters 0. Reset mid-hold aborts silently; no release pulse is emitted.
- Press latency: a pressed level first sampled at edge k gives `key_press` and `key_status` rising at edge k+2+DEBOUNCE_CYCLES, provided the level is stable throughout.
- Release latency: symmetric, k+2+DEBOUNCE_CYCLES.
- A glitch of DEBOUNCE_CYCLES−1 or fewer cycles produces no event.
- `key_long` asserts exactly LONG_CYCLES cycles after `key_press` when no release bounce occurs. Bounce cycles spent in REL_DB extend this by their count.
- First `key_repeat` comes REPEAT_CYCLES after `key_long`, then every REPEAT_CYCLES.
- All outputs are registered; pulses are exactly 1 cycle wide.

## Structure
- Package `key_pkg`: FSM state enum (RELEASED, PRESS_DB, HELD, LONG, REL_DB) and a `max3` constant function for the counter width.
- Sub-module `key_debounce_ch`: one channel (synchroniser, FSM, counters), scalar ports. The top instantiates it NUM_KEYS times in a generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, PRESS_LEVEL=0, NUM_KEYS=4.
- Clean press on key0 (pin 1→0 held 10 cycles, then 0→1) → `key_press[0]` and `key_status[0]↑` 6 cycles after the first low sample. `key_release[0]` and `key_status[0]↓` 6 cycles after the first high sample. No long pulse.
- Bounce: toggle key1 every 3 cycles ×5, then hold low → no pulse during toggling. A single `key_press[1]` 6 cycles after the final stable-low edge.
- Long hold on key2 for 60 cycles → `key_press` at t, `key_long` at t+20, `key_repeat` at t+28, t+36, t+44…, `key_release` after the pin rises.
- Release bounce in HELD: 2-cycle high glitch on key3 after 10 cycles held → no release pulse, `key_status` stays 1, and `key_long` is delayed by 2 cycles.
- Reset mid-hold: assert `sys_rst=0` while key0 is in LONG, keep the pin low → all outputs are 0 immediately. After reset release, `key_press[0]` comes 6 cycles later.
- Simultaneous: press all four keys on the same cycle → all four `key_press` bits assert on the same cycle.
